// File: rtl/xunit_sha2_pkg.sv
// Shared types and SHA-2 helper functions for the xunit_sha2 round unit.
// Helpers work on 64-bit carriers; the width argument selects SHA-256 or SHA-512.
package xunit_sha2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FFWD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int S0_32_A = 2;
  localparam int S0_32_B = 13;
  localparam int S0_32_C = 22;
  localparam int S1_32_A = 6;
  localparam int S1_32_B = 11;
  localparam int S1_32_C = 25;
  localparam int S0_64_A = 28;
  localparam int S0_64_B = 34;
  localparam int S0_64_C = 39;
  localparam int S1_64_A = 14;
  localparam int S1_64_B = 18;
  localparam int S1_64_C = 41;

  function automatic logic [63:0] word_mask(input int w);
    return (w == 64) ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
  endfunction

  // Rotate right within a w-bit word held in the low bits of x.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    logic [63:0] m;
    logic [63:0] v;
    m = word_mask(w);
    v = x & m;
    return ((v >> n) | (v << (w - n))) & m;
  endfunction

  function automatic logic [63:0] ch(input logic [63:0] e, input logic [63:0] f,
                                     input logic [63:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [63:0] maj(input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic [63:0] big_sigma0(input logic [63:0] x, input int w);
    if (w == 64)
      return rotr(x, S0_64_A, w) ^ rotr(x, S0_64_B, w) ^ rotr(x, S0_64_C, w);
    return rotr(x, S0_32_A, w) ^ rotr(x, S0_32_B, w) ^ rotr(x, S0_32_C, w);
  endfunction

  function automatic logic [63:0] big_sigma1(input logic [63:0] x, input int w);
    if (w == 64)
      return rotr(x, S1_64_A, w) ^ rotr(x, S1_64_B, w) ^ rotr(x, S1_64_C, w);
    return rotr(x, S1_32_A, w) ^ rotr(x, S1_32_B, w) ^ rotr(x, S1_32_C, w);
  endfunction

endpackage

// File: rtl/xunit_sha2_round.sv
// One combinational SHA-2 compression round: (a..h, W, K) -> (a'..h').
// State words are packed with a in the lowest WORD_W bits and h in the highest.
module sha2_round
  import xunit_sha2_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [8*WORD_W-1:0] st,
  input  logic [WORD_W-1:0]   w,
  input  logic [WORD_W-1:0]   k,
  output logic [8*WORD_W-1:0] nxt
);

  localparam int W = WORD_W;

  logic [W-1:0] a, b, c, d, e, f, g, h;
  logic [W-1:0] t1, t2;

  always_comb begin
    a  = st[0*W +: W];
    b  = st[1*W +: W];
    c  = st[2*W +: W];
    d  = st[3*W +: W];
    e  = st[4*W +: W];
    f  = st[5*W +: W];
    g  = st[6*W +: W];
    h  = st[7*W +: W];
    t1 = h + W'(big_sigma1(64'(e), W)) + W'(ch(64'(e), 64'(f), 64'(g))) + k + w;
    t2 = W'(big_sigma0(64'(a), W)) + W'(maj(64'(a), 64'(b), 64'(c)));
    nxt = {g, f, e, d + t1, c, b, a, t1 + t2};
  end

endmodule

// File: rtl/xunit_sha2.sv
// Versat SHA-2 functional unit: runs a configurable number of compression rounds,
// one per clock, with an optional feed-forward add of the initial hash.
module xunit_sha2
  import xunit_sha2_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int DELAY_W = 7,
  parameter int ROUND_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               running,
  input  logic               run,
  output logic               done,
  input  logic [WORD_W-1:0]  in0,
  input  logic [WORD_W-1:0]  in1,
  input  logic [WORD_W-1:0]  in2,
  input  logic [WORD_W-1:0]  in3,
  input  logic [WORD_W-1:0]  in4,
  input  logic [WORD_W-1:0]  in5,
  input  logic [WORD_W-1:0]  in6,
  input  logic [WORD_W-1:0]  in7,
  input  logic [WORD_W-1:0]  in8,
  input  logic [WORD_W-1:0]  in9,
  output logic [WORD_W-1:0]  out0,
  output logic [WORD_W-1:0]  out1,
  output logic [WORD_W-1:0]  out2,
  output logic [WORD_W-1:0]  out3,
  output logic [WORD_W-1:0]  out4,
  output logic [WORD_W-1:0]  out5,
  output logic [WORD_W-1:0]  out6,
  output logic [WORD_W-1:0]  out7,
  input  logic [DELAY_W-1:0] delay0,
  input  logic [ROUND_W-1:0] rounds0,
  input  logic               ffwd0,
  output logic [2:0]         dbg_state
);

  localparam int W = WORD_W;

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
    $error("xunit_sha2: WORD_W must be 32 or 64");
  end
  if (ROUND_W < 7) begin : g_bad_round_w
    $error("xunit_sha2: ROUND_W must be at least 7");
  end

  state_t             state;
  logic [DELAY_W-1:0] dcnt;
  logic [ROUND_W-1:0] rcnt;
  logic [ROUND_W-1:0] r_cfg;
  logic               ff;
  logic [8*W-1:0]     hash_q;
  logic [8*W-1:0]     out_q;
  logic [8*W-1:0]     in_flat;
  logic [8*W-1:0]     rnd_in;
  logic [8*W-1:0]     rnd_out;
  logic [8*W-1:0]     ffwd_sum;

  assign in_flat = {in7, in6, in5, in4, in3, in2, in1, in0};

  // Round 1 starts from the live inputs; later rounds chain from the registers.
  assign rnd_in = (state == ST_WAIT) ? in_flat : out_q;

  sha2_round #(.WORD_W(WORD_W)) u_round (
    .st  (rnd_in),
    .w   (in8),
    .k   (in9),
    .nxt (rnd_out)
  );

  always_comb begin
    ffwd_sum = '0;
    for (int i = 0; i < 8; i++)
      ffwd_sum[i*W +: W] = out_q[i*W +: W] + hash_q[i*W +: W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      dcnt   <= '0;
      rcnt   <= '0;
      r_cfg  <= '0;
      ff     <= 1'b0;
      hash_q <= '0;
      out_q  <= '0;
    end else if (run) begin
      dcnt  <= delay0;
      r_cfg <= rounds0;
      ff    <= ffwd0;
      rcnt  <= '0;
      state <= ST_WAIT;
    end else if (running) begin
      case (state)
        ST_WAIT: begin
          if (dcnt != '0) begin
            dcnt <= dcnt - 1'b1;
          end else begin
            hash_q <= in_flat;
            if (r_cfg == '0) begin
              out_q <= in_flat;
            end else begin
              out_q <= rnd_out;
              rcnt  <= ROUND_W'(1);
            end
            if (r_cfg > ROUND_W'(1)) state <= ST_ROUND;
            else if (ff)             state <= ST_FFWD;
            else                     state <= ST_DONE;
          end
        end
        ST_ROUND: begin
          out_q <= rnd_out;
          rcnt  <= rcnt + 1'b1;
          if (rcnt + 1'b1 == r_cfg) state <= ff ? ST_FFWD : ST_DONE;
        end
        ST_FFWD: begin
          out_q <= ffwd_sum;
          state <= ST_DONE;
        end
        default: ;
      endcase
    end
  end

  assign done      = (state == ST_IDLE) || (state == ST_DONE);
  assign dbg_state = state;

  assign out0 = out_q[0*W +: W];
  assign out1 = out_q[1*W +: W];
  assign out2 = out_q[2*W +: W];
  assign out3 = out_q[3*W +: W];
  assign out4 = out_q[4*W +: W];
  assign out5 = out_q[5*W +: W];
  assign out6 = out_q[6*W +: W];
  assign out7 = out_q[7*W +: W];

endmodule

// File: tb/tb_xunit_sha2.sv
// Directed bench for xunit_sha2: SHA-256 and SHA-512 "abc" digests, stall, restart,
// zero/one-round corner cases and asynchronous reset.
module tb_xunit_sha2;
  import xunit_sha2_pkg::*;

  logic        clk = 1'b0;
  logic        rst, running, run, ffwd0;
  logic [6:0]  delay0, rounds0;
  logic [31:0] i32 [10];
  logic [63:0] i64 [10];
  logic [31:0] o32 [8];
  logic [63:0] o64 [8];
  logic        done32, done64;
  logic [2:0]  st32, st64;

  logic [31:0] k32 [80];
  logic [31:0] w32 [80];
  logic [63:0] k64 [80];
  logic [63:0] w64 [80];

  int vectors = 0;
  int fails   = 0;
  int de;

  localparam logic [31:0] IV32 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [63:0] IV64 [8] = '{64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
                                       64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                                       64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
                                       64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam logic [31:0] DIG32 [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [63:0] DIG64 [8] = '{64'hddaf35a193617aba, 64'hcc417349ae204131,
                                        64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
                                        64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd,
                                        64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};
  localparam logic [31:0] RND1 [8] = '{32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
                                       32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab};

  always #5 clk = ~clk;

  xunit_sha2 #(.WORD_W(32), .DELAY_W(7), .ROUND_W(7)) dut32 (
    .clk(clk), .rst(rst), .running(running), .run(run), .done(done32),
    .in0(i32[0]), .in1(i32[1]), .in2(i32[2]), .in3(i32[3]), .in4(i32[4]),
    .in5(i32[5]), .in6(i32[6]), .in7(i32[7]), .in8(i32[8]), .in9(i32[9]),
    .out0(o32[0]), .out1(o32[1]), .out2(o32[2]), .out3(o32[3]),
    .out4(o32[4]), .out5(o32[5]), .out6(o32[6]), .out7(o32[7]),
    .delay0(delay0), .rounds0(rounds0), .ffwd0(ffwd0), .dbg_state(st32)
  );

  xunit_sha2 #(.WORD_W(64), .DELAY_W(7), .ROUND_W(7)) dut64 (
    .clk(clk), .rst(rst), .running(running), .run(run), .done(done64),
    .in0(i64[0]), .in1(i64[1]), .in2(i64[2]), .in3(i64[3]), .in4(i64[4]),
    .in5(i64[5]), .in6(i64[6]), .in7(i64[7]), .in8(i64[8]), .in9(i64[9]),
    .out0(o64[0]), .out1(o64[1]), .out2(o64[2]), .out3(o64[3]),
    .out4(o64[4]), .out5(o64[5]), .out6(o64[6]), .out7(o64[7]),
    .delay0(delay0), .rounds0(rounds0), .ffwd0(ffwd0), .dbg_state(st64)
  );

  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] r64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Round constant: first n bits of the fractional part of cbrt(p), by integer cube root.
  function automatic logic [63:0] cbrt_k(input int p, input int n);
    logic [255:0] tgt, lo, hi, mid;
    tgt = 256'(p) << (3 * n);
    lo  = '0;
    hi  = 256'd1 << (n + 3);
    while (hi - lo > 256'd1) begin
      mid = (lo + hi) >> 1;
      if (mid * mid * mid <= tgt) lo = mid;
      else                        hi = mid;
    end
    return (n == 32) ? {32'h0, lo[31:0]} : lo[63:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_dig32(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_w%0d", tag, i), 64'(o32[i]), 64'(DIG32[i]));
  endtask

  // Start an operation and stream W/K until done (or stop_after edges); returns the
  // edge count after the run edge at which done was first seen, -1 if never.
  task automatic run_op(input bit use64, input int d, input int r, input bit f,
                        input int stall_at, input int stall_len, input int stop_after,
                        output int done_edge);
    int n, edges, stalled, tn, idx;
    @(negedge clk);
    delay0 = 7'(d); rounds0 = 7'(r); ffwd0 = f; run = 1'b1; running = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    n = 0; edges = 0; stalled = 0; done_edge = -1;
    while (done_edge < 0 && edges < stop_after) begin
      tn  = (n - d + 1 < 1) ? 1 : n - d + 1;
      idx = (tn - 1 > 79) ? 79 : tn - 1;
      i32[8] = w32[idx]; i32[9] = k32[idx];
      i64[8] = w64[idx]; i64[9] = k64[idx];
      running = 1'b1;
      if (stall_at > 0 && tn == stall_at && stalled < stall_len) begin
        running = 1'b0;
        stalled++;
      end
      @(posedge clk);
      edges++;
      if (running) n++;
      @(negedge clk);
      if (use64 ? done64 : done32) done_edge = edges;
    end
    running = 1'b1;
  endtask

  initial begin
    int p, cnt;
    bit prime;
    // Constant and "abc" message-schedule tables.
    cnt = 0;
    p = 2;
    while (cnt < 80) begin
      prime = 1'b1;
      for (int q = 2; q * q <= p; q++) if (p % q == 0) prime = 1'b0;
      if (prime) begin
        k32[cnt] = 32'(cbrt_k(p, 32));
        k64[cnt] = cbrt_k(p, 64);
        cnt++;
      end
      p++;
    end
    for (int t = 0; t < 16; t++) begin
      w32[t] = '0;
      w64[t] = '0;
    end
    w32[0] = 32'h61626380; w32[15] = 32'h18;
    w64[0] = 64'h6162638000000000; w64[15] = 64'h18;
    for (int t = 16; t < 80; t++) begin
      w32[t] = (r32(w32[t-2], 17) ^ r32(w32[t-2], 19) ^ (w32[t-2] >> 10)) + w32[t-7]
             + (r32(w32[t-15], 7) ^ r32(w32[t-15], 18) ^ (w32[t-15] >> 3)) + w32[t-16];
      w64[t] = (r64(w64[t-2], 19) ^ r64(w64[t-2], 61) ^ (w64[t-2] >> 6)) + w64[t-7]
             + (r64(w64[t-15], 1) ^ r64(w64[t-15], 8) ^ (w64[t-15] >> 7)) + w64[t-16];
    end

    rst = 1'b1; running = 1'b0; run = 1'b0; ffwd0 = 1'b0;
    delay0 = '0; rounds0 = '0;
    for (int i = 0; i < 8; i++) begin
      i32[i] = IV32[i];
      i64[i] = IV64[i];
    end
    i32[8] = '0; i32[9] = '0; i64[8] = '0; i64[9] = '0;

    #12;
    check("reset_done32", 64'(done32), 64'd1);
    check("reset_done64", 64'(done64), 64'd1);
    check("reset_state", 64'(st32), 64'(ST_IDLE));
    for (int i = 0; i < 8; i++) check($sformatf("reset_out32_%0d", i), 64'(o32[i]), 64'd0);
    check("reset_out64_0", o64[0], 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_out0", 64'(o32[0]), 64'd0);
    check("post_reset_done", 64'(done32), 64'd1);

    run_op(1'b0, 3, 64, 1'b1, 0, 0, 200, de);
    check("sha256_done_edge", 64'(de), 64'd68);
    check_dig32("sha256");

    run_op(1'b1, 2, 80, 1'b1, 0, 0, 200, de);
    check("sha512_done_edge", 64'(de), 64'd83);
    for (int i = 0; i < 8; i++) check($sformatf("sha512_w%0d", i), o64[i], DIG64[i]);

    run_op(1'b0, 0, 0, 1'b1, 0, 0, 20, de);
    check("r0_done_edge", 64'(de), 64'd2);
    check("r0_out0", 64'(o32[0]), 64'hd413ccce);
    check("r0_out7", 64'(o32[7]), 64'hb7c19a32);
    check("r0_out64_0", o64[0], 64'hd413cccfe7799210);

    run_op(1'b0, 3, 64, 1'b1, 10, 5, 200, de);
    check("stall_done_edge", 64'(de), 64'd73);
    check_dig32("stall");

    run_op(1'b0, 3, 64, 1'b1, 0, 0, 33, de);
    check("restart_busy", 64'(done32), 64'd0);
    run_op(1'b0, 3, 64, 1'b1, 0, 0, 200, de);
    check("restart_done_edge", 64'(de), 64'd68);
    check_dig32("restart");

    run_op(1'b0, 2, 1, 1'b0, 0, 0, 20, de);
    check("r1_done_edge", 64'(de), 64'd3);
    for (int i = 0; i < 8; i++) check($sformatf("r1_w%0d", i), 64'(o32[i]), 64'(RND1[i]));
    for (int c = 0; c < 4; c++) begin
      i32[8] = $urandom_range(32'hffff_ffff, 0);
      i32[9] = $urandom_range(32'hffff_ffff, 0);
      @(posedge clk);
      @(negedge clk);
    end
    check("done_hold_out0", 64'(o32[0]), 64'(RND1[0]));
    check("done_hold_out4", 64'(o32[4]), 64'(RND1[4]));
    check("done_hold_done", 64'(done32), 64'd1);

    run_op(1'b0, 3, 64, 1'b1, 0, 0, 20, de);
    check("midop_busy", 64'(done32), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("midop_rst_done", 64'(done32), 64'd1);
    check("midop_rst_out0", 64'(o32[0]), 64'd0);
    check("midop_rst_out7", 64'(o32[7]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midop_after_out4", 64'(o32[4]), 64'd0);
    check("midop_after_done", 64'(done32), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
